// File: rtl/slip_pkg.sv
// Shared SLIP byte codes, frame FSM states and escaping helpers.
package slip_pkg;

  localparam logic [7:0] SLIP_END     = 8'hC0;
  localparam logic [7:0] SLIP_ESC     = 8'hDB;
  localparam logic [7:0] SLIP_ESC_END = 8'hDC;
  localparam logic [7:0] SLIP_ESC_ESC = 8'hDD;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    TAG,
    DATA,
    ESC2,
    TERM
  } state_e;

  function automatic logic needs_esc(input logic [7:0] b);
    return (b == SLIP_END) || (b == SLIP_ESC);
  endfunction

  function automatic logic [7:0] esc_first(input logic [7:0] b);
    return needs_esc(b) ? SLIP_ESC : b;
  endfunction

  function automatic logic [7:0] esc_second(input logic [7:0] b);
    return (b == SLIP_END) ? SLIP_ESC_END : SLIP_ESC_ESC;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin requester selection; pointer moves past the winner on advance.
module rr_arbiter #(
  parameter int unsigned N = 2,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] ptr_q, ptr_d;

  // Scan from the farthest candidate back to ptr so the nearest requester wins.
  always_comb begin
    int c;
    grant = '0;
    idx   = '0;
    c     = 0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      c = (int'(ptr_q) + k) % int'(N);
      if (req[c]) begin
        grant    = '0;
        grant[c] = 1'b1;
        idx      = IW'(c);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (idx == IW'(N - 1)) ? '0 : idx + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/slip_frame_tx.sv
// Arbitrates message channels and streams each message as one SLIP-encoded frame.
module slip_frame_tx
  import slip_pkg::*;
#(
  parameter int unsigned MSG_BYTES = 5,
  parameter int unsigned N_CHAN    = 2,
  parameter int unsigned TAG_EN    = 1,
  parameter int unsigned LEAD_END  = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_CHAN*MSG_BYTES*8-1:0] msg_in,
  input  logic [N_CHAN-1:0]             msg_valid,
  output logic [N_CHAN-1:0]             msg_ack,
  output logic [7:0]                    out_byte,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          busy,
  output logic [15:0]                   frame_count
);

  localparam int unsigned MSG_W = MSG_BYTES * 8;
  localparam int unsigned CNT_W = $clog2(MSG_BYTES + 1);
  localparam int unsigned IW    = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
  localparam state_e POST_LEAD  = (TAG_EN != 0) ? TAG : DATA;
  localparam state_e FIRST_ST   = (LEAD_END != 0) ? LEAD : POST_LEAD;

  state_e           state_q, state_d;
  logic [MSG_W-1:0] msg_q, msg_d;
  logic [7:0]       tag_q, tag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             esc_tag_q, esc_tag_d;
  logic [7:0]       byte_q, byte_d;
  logic             valid_q, valid_d;
  logic [15:0]      fcnt_q, fcnt_d;

  logic [N_CHAN-1:0] grant;
  logic [IW-1:0]     gidx;
  logic              idle, advance, xfer, next_data;

  assign idle = (state_q == IDLE);
  assign xfer = valid_q & out_ready;

  rr_arbiter #(.N(N_CHAN)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (msg_valid),
    .advance (advance),
    .grant   (grant),
    .idx     (gidx)
  );

  // Pop strobe is combinational from the grant and is held low throughout reset.
  assign msg_ack     = (idle && rst_n) ? grant : '0;
  assign out_byte    = byte_q;
  assign out_valid   = valid_q;
  assign busy        = valid_q;
  assign frame_count = fcnt_q;

  // Byte presented in state s; the payload's current byte is always the top of msg.
  function automatic logic [7:0] emit(input state_e s, input logic [MSG_W-1:0] m,
                                      input logic [7:0] t, input logic et);
    case (s)
      LEAD, TERM: return SLIP_END;
      TAG:        return esc_first(t);
      DATA:       return esc_first(m[MSG_W-1 -: 8]);
      ESC2:       return esc_second(et ? t : m[MSG_W-1 -: 8]);
      default:    return 8'h00;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    msg_d     = msg_q;
    tag_d     = tag_q;
    cnt_d     = cnt_q;
    esc_tag_d = esc_tag_q;
    fcnt_d    = fcnt_q;
    advance   = 1'b0;
    next_data = 1'b0;
    case (state_q)
      IDLE: begin
        if (|msg_valid) begin
          advance = 1'b1;
          msg_d   = msg_in[gidx*MSG_W +: MSG_W];
          tag_d   = 8'(gidx);
          cnt_d   = CNT_W'(MSG_BYTES);
          state_d = FIRST_ST;
        end
      end
      LEAD: if (xfer) state_d = POST_LEAD;
      TAG: begin
        if (xfer) begin
          if (needs_esc(tag_q)) begin
            esc_tag_d = 1'b1;
            state_d   = ESC2;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (xfer) begin
          if (needs_esc(msg_q[MSG_W-1 -: 8])) begin
            esc_tag_d = 1'b0;
            state_d   = ESC2;
          end else begin
            next_data = 1'b1;
          end
        end
      end
      ESC2: begin
        if (xfer) begin
          if (esc_tag_q) state_d = DATA;
          else           next_data = 1'b1;
        end
      end
      TERM: begin
        if (xfer) begin
          fcnt_d  = fcnt_q + 16'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (next_data) begin
      msg_d   = msg_q << 8;
      cnt_d   = cnt_q - CNT_W'(1);
      state_d = (cnt_q == CNT_W'(1)) ? TERM : DATA;
    end
    byte_d  = emit(state_d, msg_d, tag_d, esc_tag_d);
    valid_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      msg_q     <= '0;
      tag_q     <= '0;
      cnt_q     <= '0;
      esc_tag_q <= 1'b0;
      byte_q    <= 8'h00;
      valid_q   <= 1'b0;
      fcnt_q    <= 16'h0000;
    end else begin
      state_q   <= state_d;
      msg_q     <= msg_d;
      tag_q     <= tag_d;
      cnt_q     <= cnt_d;
      esc_tag_q <= esc_tag_d;
      byte_q    <= byte_d;
      valid_q   <= valid_d;
      fcnt_q    <= fcnt_d;
    end
  end

endmodule
